hilo_div_ctrl: RTL and testbench

- Multi-cycle divide sequencer for the HI/LO result path.
- Accepts a DIV/DIVU issue from EX and runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds the pipeline stall while busy, then presents quotient (LO) and remainder (HI) with a writeHILO strobe to the MEM-stage HI/LO write path.
- A flush cancels an in-flight divide without writing HI/LO.

---
 rtl/hilo_div_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// Multi-cycle divide sequencer for the HI/LO result path. A DIV/DIVU issue
// from EX is run as a radix-2 restoring divide on operand magnitudes, one
// quotient bit per cycle. The pipeline is held while the divide runs. The
// quotient (LO) and remainder (HI) are then presented for one cycle with a
// writeHILO strobe to the MEM-stage HI/LO write path.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      issue request, sampled only in IDLE
//   signed_i     1 = DIV (signed), 0 = DIVU; captured with start_i
//   dividend_i   dividend; captured with start_i
//   divisor_i    divisor; captured with start_i
//   cancel_i     pipeline flush; aborts any operation
//   stall_o      pipeline stall request
//   done_o       one-cycle result-valid pulse
//   writeHILO_o  2'b11 while the result is written, else 2'b00
//   HI_data_o    remainder (registered, holds outside DONE)
//   LO_data_o    quotient  (registered, holds outside DONE)
//   divByZero_o  present only when HILO_DIV_ZERO_FLAG_EN is defined;
//                high with done_o when the captured divisor was zero
//
// Optional feature macro: HILO_DIV_ZERO_FLAG_EN

module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [1:0]       writeHILO_o,
    output logic [WIDTH-1:0] HI_data_o,
    output logic [WIDTH-1:0] LO_data_o
`ifdef HILO_DIV_ZERO_FLAG_EN
    ,
    output logic             divByZero_o
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div_mag;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             last_iter;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

`ifdef HILO_DIV_ZERO_FLAG_EN
    logic             dbz_flag;
`endif

    // Signed operands are reduced to magnitudes up front so that the
    // iteration itself is purely unsigned; the sign fix-up happens once when
    // the result is registered. The most negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    always_comb begin
        divisor_zero = (divisor_i == '0);
        dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
        divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    end

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
    // rem is always below div_mag, so the shifted value fits in WIDTH+1 bits
    // and a kept difference fits back into WIDTH bits.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, div_mag};
        if (!rem_trial[WIDTH]) begin
            rem_next = rem_trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Cancel outranks everything. In DONE it suppresses the strobe in the same
    // cycle; in RUN it drops straight back to IDLE without a write.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        writeHILO_o = 2'b00;
        accept      = 1'b0;
        last_iter   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    accept     = 1'b1;
                    stall_o    = 1'b1;
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                stall_o = 1'b1;
                if (cancel_i) begin
                    state_next = IDLE;
                end else if (counter == CNT_W'(WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!cancel_i) begin
                    done_o      = 1'b1;
                    writeHILO_o = 2'b11;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers are loaded on the transition into DONE so they are
    // valid during DONE and simply hold afterwards. A divide by zero loads
    // them directly at issue time and bypasses the iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            rem       <= '0;
            quo       <= '0;
            div_mag   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            HI_data_o <= '0;
            LO_data_o <= '0;
        end else if (accept) begin
            counter <= '0;
            rem     <= '0;
            quo     <= dividend_mag;
            div_mag <= divisor_mag;
            neg_quo <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem <= signed_i & dividend_i[WIDTH-1];
            if (divisor_zero) begin
                LO_data_o <= '1;
                HI_data_o <= dividend_i;
            end
        end else if (state == RUN && !cancel_i) begin
            counter <= counter + 1'b1;
            rem     <= rem_next;
            quo     <= quo_next;
            if (last_iter) begin
                LO_data_o <= neg_quo ? -quo_next : quo_next;
                HI_data_o <= neg_rem ? -rem_next : rem_next;
            end
        end
    end

`ifdef HILO_DIV_ZERO_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbz_flag <= 1'b0;
        end else if (accept) begin
            dbz_flag <= divisor_zero;
        end
    end

    assign divByZero_o = done_o & dbz_flag;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl
// Self-checking bench for hilo_div_ctrl (WIDTH = 32). Table-driven divide
// vectors are issued one at a time; the expected result and latency are
// pushed to a scoreboard at issue and popped when done_o appears. Hand
// sequences cover cancel in RUN, asynchronous reset mid-RUN and a
// back-to-back issue with start held high.

module tb_hilo_div_ctrl;

    localparam int W = 32;
    localparam int RUN_LAT = W + 1;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         cancel_i;
    logic         stall_o;
    logic         done_o;
    logic [1:0]   writeHILO_o;
    logic [W-1:0] HI_data_o;
    logic [W-1:0] LO_data_o;
`ifdef HILO_DIV_ZERO_FLAG_EN
    logic         divByZero_o;
`endif

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .writeHILO_o (writeHILO_o),
        .HI_data_o   (HI_data_o),
        .LO_data_o   (LO_data_o)
`ifdef HILO_DIV_ZERO_FLAG_EN
        ,
        .divByZero_o (divByZero_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one divide in the current cycle (N) and leave start low from N+1.
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] elo, input logic [W-1:0] ehi, input int lat);
        exp_t e;
        @(negedge clk);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        e.lo  = elo;
        e.hi  = ehi;
        e.dbz = (b == '0);
        e.lat = lat;
        sb.push_back(e);
        #1;
        check("stall_issue", stall_o, 1);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Called at the negedge of cycle N+1; waits (bounded) for done_o and
    // compares it against the oldest scoreboard entry.
    task automatic checkOutput(input string name);
        exp_t e;
        int   cyc;
        int   stall_gaps;
        int   early_writes;
        bit   seen;
        cyc          = 1;
        stall_gaps   = 0;
        early_writes = 0;
        seen         = 1'b0;
        while (cyc <= RUN_LAT + 8 && !seen) begin
            #1;
            if (done_o) begin
                seen = 1'b1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({name, "_latency"}, cyc, e.lat);
                    check({name, "_lo"}, LO_data_o, e.lo);
                    check({name, "_hi"}, HI_data_o, e.hi);
                    check({name, "_write"}, writeHILO_o, 2'b11);
                    check({name, "_stall_done"}, stall_o, 0);
                    check({name, "_stall_run"}, stall_gaps, 0);
                    check({name, "_early_write"}, early_writes, 0);
`ifdef HILO_DIV_ZERO_FLAG_EN
                    check({name, "_dbz"}, divByZero_o, e.dbz);
`endif
                end else begin
                    check({name, "_unexpected_done"}, 1, 0);
                end
            end else begin
                if (!stall_o) stall_gaps++;
                if (writeHILO_o != 2'b00) early_writes++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int quiet_bad;
        exp_t e;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        cancel_i   = 1'b0;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        RUN_LAT};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, RUN_LAT};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        RUN_LAT};
        vecs[3]  = '{1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFF, 32'h12345678, 1};
        vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        RUN_LAT};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        32'd0,        RUN_LAT};
        vecs[7]  = '{1'b0, 32'd5,         32'd10,       32'd0,        32'd5,        RUN_LAT};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, RUN_LAT};
        vecs[9]  = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 32'd1,        RUN_LAT};
        vecs[10] = '{1'b0, 32'hDEADBEEF,  32'h10,       32'h0DEADBEE, 32'hF,        RUN_LAT};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", stall_o, 0);
        check("reset_done", done_o, 0);
        check("reset_write", writeHILO_o, 0);
        check("reset_lo", LO_data_o, 0);
        check("reset_hi", HI_data_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].lat);
            checkOutput($sformatf("vec%0d", i));
        end

        // Cancel in RUN cycle N+10
        @(negedge clk);
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd7;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        cancel_i = 1'b1;
        #1;
        check("cancel_stall_run", stall_o, 1);
        @(negedge clk);
        cancel_i = 1'b0;
        #1;
        check("cancel_stall_after", stall_o, 0);
        quiet_bad = 0;
        for (int c = 0; c < RUN_LAT + 5; c++) begin
            if (done_o || writeHILO_o != 2'b00 || stall_o) quiet_bad++;
            @(negedge clk);
            #1;
        end
        check("cancel_no_result", quiet_bad, 0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_pre_stall", stall_o, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_stall", stall_o, 0);
        check("rst_async_done", done_o, 0);
        check("rst_async_write", writeHILO_o, 0);
        check("rst_async_lo", LO_data_o, 0);
        check("rst_async_hi", HI_data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, RUN_LAT);
        checkOutput("post_rst");

        // Back-to-back with start held high throughout
        @(negedge clk);
        signed_i   = 1'b0;
        dividend_i = 32'hFFFFFFFF;
        divisor_i  = 32'd1;
        start_i    = 1'b1;
        e.lo  = 32'hFFFFFFFF;
        e.hi  = 32'd0;
        e.dbz = 1'b0;
        e.lat = RUN_LAT;
        sb.push_back(e);
        @(negedge clk);
        dividend_i = 32'd10;
        divisor_i  = 32'd3;
        checkOutput("b2b_first");
        e.lo  = 32'd3;
        e.hi  = 32'd1;
        e.dbz = 1'b0;
        e.lat = RUN_LAT;
        sb.push_back(e);
        @(negedge clk);
        #1;
        check("b2b_accept_stall", stall_o, 1);
        check("b2b_idle_done", done_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("b2b_second");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
